// File: rtl/decode_stage.sv
// MIPS-subset decode stage: register file, load-use scoreboard, branch-shadow
// freeze counter with optional static prediction, and the ID/EX register.
module decode_stage #(
  parameter int unsigned DW        = 32,
  parameter int unsigned NREG      = 32,
  parameter int unsigned PCW       = 8,
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned BR_SHADOW = 1,
  parameter bit          BP_EN     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_valid,
  input  logic [31:0]             if_inst,
  input  logic [PCW-1:0]          if_pcadd,
  input  logic                    flush,
  input  logic                    wb_we,
  input  logic [$clog2(NREG)-1:0] wb_addr,
  input  logic [DW-1:0]           wb_data,
  output logic                    pc_write,
  output logic                    ifid_write,
  output logic                    freeze,
  output logic                    ex_valid,
  output logic                    ex_memtoreg,
  output logic                    ex_memwrite,
  output logic                    ex_branch,
  output logic                    ex_alusrc,
  output logic                    ex_regdst,
  output logic                    ex_regwrite,
  output logic                    ex_jump,
  output logic                    ex_jr,
  output logic                    ex_ld,
  output logic                    ex_pred_taken,
  output logic                    ex_illegal,
  output logic [4:0]              ex_alu_op,
  output logic [DW-1:0]           ex_rs_data,
  output logic [DW-1:0]           ex_rt_data,
  output logic [DW-1:0]           ex_imm,
  output logic [$clog2(NREG)-1:0] ex_rs,
  output logic [$clog2(NREG)-1:0] ex_rt,
  output logic [$clog2(NREG)-1:0] ex_rd,
  output logic [PCW-1:0]          ex_pcadd
);

  localparam int unsigned RAW = $clog2(NREG);

  typedef struct packed {
    logic           valid;
    logic           memtoreg;
    logic           memwrite;
    logic           branch;
    logic           alusrc;
    logic           regdst;
    logic           regwrite;
    logic           jump;
    logic           jr;
    logic           ld;
    logic           pred_taken;
    logic           illegal;
    logic [4:0]     alu_op;
    logic [DW-1:0]  rs_data;
    logic [DW-1:0]  rt_data;
    logic [DW-1:0]  imm;
    logic [RAW-1:0] rs;
    logic [RAW-1:0] rt;
    logic [RAW-1:0] rd;
    logic [PCW-1:0] pcadd;
  } ex_t;

  logic [5:0]     opcode, funct;
  logic [4:0]     shamt, rt_f;
  logic [15:0]    imm16;
  logic [RAW-1:0] rs_a, rt_a, rd_a;

  assign opcode = if_inst[31:26];
  assign rt_f   = if_inst[20:16];
  assign shamt  = if_inst[10:6];
  assign funct  = if_inst[5:0];
  assign imm16  = if_inst[15:0];
  assign rs_a   = if_inst[21 +: RAW];
  assign rt_a   = if_inst[16 +: RAW];
  assign rd_a   = if_inst[11 +: RAW];

  logic [DW-1:0]  rf_q [NREG];
  logic [DW-1:0]  rf_d [NREG];
  ex_t            ex_q, ex_d, dec;
  logic [1:0]     brc_q, brc_d;
  logic [LOAD_LAT-1:0] sb_vld_q, sb_vld_d;
  logic [RAW-1:0] sb_dst_q [LOAD_LAT];
  logic [RAW-1:0] sb_dst_d [LOAD_LAT];
  logic           d_legal, d_nop, d_cond, d_sext, d_zext;
  logic           hazard, stall, issue, frz_issue;

  // Reads see rf_d, which gives same-cycle write-through; entry 0 is never written.
  always_comb begin
    rf_d = rf_q;
    if (wb_we && wb_addr != '0) rf_d[wb_addr] = wb_data;
  end

  always_comb begin
    dec     = '0;
    d_legal = 1'b1;
    d_nop   = 1'b0;
    d_cond  = 1'b0;
    d_sext  = 1'b0;
    d_zext  = 1'b0;
    case (opcode)
      6'h00: begin
        dec.regdst   = 1'b1;
        dec.regwrite = 1'b1;
        case (funct)
          6'h00: begin
            if (shamt == 5'd0) d_nop = 1'b1;
            else begin dec.alu_op = 5'h09; dec.alusrc = 1'b1; d_zext = 1'b1; end
          end
          6'h02: begin dec.alu_op = 5'h14; dec.alusrc = 1'b1; d_zext = 1'b1; end
          6'h04: dec.alu_op = 5'h13;
          6'h06: dec.alu_op = 5'h15;
          6'h08: begin
            dec.alu_op = 5'h10; dec.branch = 1'b1; dec.jr = 1'b1; dec.regwrite = 1'b0;
          end
          6'h20, 6'h21: dec.alu_op = 5'h01;
          6'h22, 6'h23: dec.alu_op = 5'h02;
          6'h24: dec.alu_op = 5'h03;
          6'h25: dec.alu_op = 5'h04;
          6'h26: dec.alu_op = 5'h05;
          6'h27: dec.alu_op = 5'h06;
          default: d_legal = 1'b0;
        endcase
      end
      6'h01: begin
        dec.branch = 1'b1; d_cond = 1'b1; d_sext = 1'b1;
        if (rt_f == 5'd0)      dec.alu_op = 5'h16;
        else if (rt_f == 5'd1) dec.alu_op = 5'h17;
        else                   d_legal = 1'b0;
      end
      6'h02: begin dec.alu_op = 5'h10; dec.branch = 1'b1; dec.jump = 1'b1; end
      6'h04: begin dec.alu_op = 5'h12; dec.branch = 1'b1; d_cond = 1'b1; d_sext = 1'b1; end
      6'h05: begin dec.alu_op = 5'h11; dec.branch = 1'b1; d_cond = 1'b1; d_sext = 1'b1; end
      6'h07: begin dec.alu_op = 5'h07; dec.branch = 1'b1; d_cond = 1'b1; d_sext = 1'b1; end
      6'h08: begin dec.alu_op = 5'h01; dec.alusrc = 1'b1; dec.regwrite = 1'b1; d_sext = 1'b1; end
      6'h0C: begin dec.alu_op = 5'h03; dec.alusrc = 1'b1; dec.regwrite = 1'b1; d_zext = 1'b1; end
      6'h0D: begin dec.alu_op = 5'h04; dec.alusrc = 1'b1; dec.regwrite = 1'b1; d_zext = 1'b1; end
      6'h0E: begin dec.alu_op = 5'h05; dec.alusrc = 1'b1; dec.regwrite = 1'b1; d_zext = 1'b1; end
      6'h0F: begin dec.alu_op = 5'h08; dec.alusrc = 1'b1; dec.regwrite = 1'b1; d_zext = 1'b1; end
      6'h23: begin
        dec.alu_op = 5'h01; dec.alusrc = 1'b1; dec.regwrite = 1'b1;
        dec.memtoreg = 1'b1; dec.ld = 1'b1; d_sext = 1'b1;
      end
      6'h2B: begin dec.alu_op = 5'h01; dec.alusrc = 1'b1; dec.memwrite = 1'b1; d_sext = 1'b1; end
      default: d_legal = 1'b0;
    endcase
    if (d_sext)      dec.imm = DW'($signed(imm16));
    else if (d_zext) dec.imm = DW'(imm16);
    dec.pred_taken = d_cond & BP_EN & imm16[15];
    dec.rs         = rs_a;
    dec.rt         = rt_a;
    dec.rd         = rd_a;
    dec.rs_data    = rf_d[rs_a];
    dec.rt_data    = rf_d[rt_a];
    dec.pcadd      = if_pcadd;
    dec.valid      = d_legal & ~d_nop;
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (sb_vld_q[i] && ((rs_a != '0 && rs_a == sb_dst_q[i]) ||
                          (rt_a != '0 && rt_a == sb_dst_q[i]))) hazard = 1'b1;
    end
  end

  assign freeze     = (brc_q != 2'd0);
  assign stall      = ~rst & if_valid & ~flush & ~freeze & hazard;
  assign issue      = if_valid & ~flush & ~freeze & ~stall;
  assign pc_write   = ~stall;
  assign ifid_write = ~stall;

  always_comb begin
    ex_d = '0;
    if (issue) begin
      if (dec.valid) ex_d = dec;
      else           ex_d.illegal = ~d_legal;
    end
  end

  // Forward conditional branches skip the shadow only when prediction is enabled.
  assign frz_issue = ex_d.valid & (ex_d.jump | ex_d.jr | (d_cond & ~(BP_EN & ~imm16[15])));

  always_comb begin
    brc_d = brc_q;
    if (flush)          brc_d = 2'd0;
    else if (freeze)    brc_d = brc_q - 2'd1;
    else if (frz_issue) brc_d = 2'(BR_SHADOW);
  end

  always_comb begin
    sb_vld_d    = sb_vld_q;
    sb_dst_d    = sb_dst_q;
    sb_vld_d[0] = ex_d.valid & ex_d.ld;
    sb_dst_d[0] = rt_a;
    for (int i = 1; i < LOAD_LAT; i++) begin
      sb_vld_d[i] = sb_vld_q[i-1];
      sb_dst_d[i] = sb_dst_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q     <= '0;
      brc_q    <= 2'd0;
      sb_vld_q <= '0;
      for (int i = 0; i < LOAD_LAT; i++) sb_dst_q[i] <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      ex_q     <= ex_d;
      brc_q    <= brc_d;
      sb_vld_q <= sb_vld_d;
      sb_dst_q <= sb_dst_d;
      rf_q     <= rf_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_memtoreg   = ex_q.memtoreg;
  assign ex_memwrite   = ex_q.memwrite;
  assign ex_branch     = ex_q.branch;
  assign ex_alusrc     = ex_q.alusrc;
  assign ex_regdst     = ex_q.regdst;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_jump       = ex_q.jump;
  assign ex_jr         = ex_q.jr;
  assign ex_ld         = ex_q.ld;
  assign ex_pred_taken = ex_q.pred_taken;
  assign ex_illegal    = ex_q.illegal;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_rs_data    = ex_q.rs_data;
  assign ex_rt_data    = ex_q.rt_data;
  assign ex_imm        = ex_q.imm;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_rd         = ex_q.rd;
  assign ex_pcadd      = ex_q.pcadd;

endmodule

// File: tb/tb_decode_stage.sv
// Randomised bench for decode_stage against a cycle-count based reference model.
module tb_decode_stage;
  localparam int unsigned DW = 32, NREG = 32, PCW = 8, LOAD_LAT = 2, BR_SHADOW = 2;
  localparam bit BP_EN = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_valid, flush, wb_we;
  logic [31:0] if_inst, wb_data;
  logic [7:0]  if_pcadd;
  logic [4:0]  wb_addr;
  logic        pc_write, ifid_write, freeze, ex_valid, ex_memtoreg, ex_memwrite, ex_branch;
  logic        ex_alusrc, ex_regdst, ex_regwrite, ex_jump, ex_jr, ex_ld, ex_pred_taken;
  logic        ex_illegal;
  logic [4:0]  ex_alu_op, ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [7:0]  ex_pcadd;

  decode_stage #(.DW(DW), .NREG(NREG), .PCW(PCW), .LOAD_LAT(LOAD_LAT),
                 .BR_SHADOW(BR_SHADOW), .BP_EN(BP_EN)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pcadd(if_pcadd),
    .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc_write(pc_write), .ifid_write(ifid_write), .freeze(freeze), .ex_valid(ex_valid),
    .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst), .ex_regwrite(ex_regwrite),
    .ex_jump(ex_jump), .ex_jr(ex_jr), .ex_ld(ex_ld), .ex_pred_taken(ex_pred_taken),
    .ex_illegal(ex_illegal), .ex_alu_op(ex_alu_op), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_pcadd(ex_pcadd)
  );

  int n_checks = 0, n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef enum {CatIll, CatNop, CatRAlu, CatRShamt, CatJr, CatJ, CatCbr,
                CatISext, CatIZext, CatLw, CatSw} cat_e;

  typedef struct packed {
    logic valid, memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump, jr, ld, pred, ill;
    logic [4:0]  alu;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic [7:0]  pcadd;
  } exp_t;

  // Reference model state: architectural registers, issue cycles of pending loads,
  // and the last cycle during which fetch is frozen.
  logic [31:0] m_rf [32];
  int          ld_dst[$];
  int          ld_cyc[$];
  int          cyc = 0, frz_last = -1;
  bit          last_stall = 0;
  int          pcw_low = 0, frz_hi = 0;

  function automatic cat_e classify(input logic [31:0] inst, output logic [4:0] alu);
    logic [5:0] op, fn;
    logic [4:0] sh, rt;
    op = inst[31:26]; fn = inst[5:0]; sh = inst[10:6]; rt = inst[20:16];
    alu = 5'h00;
    case (op)
      6'h00: case (fn)
        6'h00: begin if (sh == 5'd0) return CatNop; alu = 5'h09; return CatRShamt; end
        6'h02: begin alu = 5'h14; return CatRShamt; end
        6'h04: begin alu = 5'h13; return CatRAlu; end
        6'h06: begin alu = 5'h15; return CatRAlu; end
        6'h08: begin alu = 5'h10; return CatJr; end
        6'h20, 6'h21: begin alu = 5'h01; return CatRAlu; end
        6'h22, 6'h23: begin alu = 5'h02; return CatRAlu; end
        6'h24: begin alu = 5'h03; return CatRAlu; end
        6'h25: begin alu = 5'h04; return CatRAlu; end
        6'h26: begin alu = 5'h05; return CatRAlu; end
        6'h27: begin alu = 5'h06; return CatRAlu; end
        default: return CatIll;
      endcase
      6'h01: begin
        if (rt == 5'd0) begin alu = 5'h16; return CatCbr; end
        if (rt == 5'd1) begin alu = 5'h17; return CatCbr; end
        return CatIll;
      end
      6'h02: begin alu = 5'h10; return CatJ; end
      6'h04: begin alu = 5'h12; return CatCbr; end
      6'h05: begin alu = 5'h11; return CatCbr; end
      6'h07: begin alu = 5'h07; return CatCbr; end
      6'h08: begin alu = 5'h01; return CatISext; end
      6'h0C: begin alu = 5'h03; return CatIZext; end
      6'h0D: begin alu = 5'h04; return CatIZext; end
      6'h0E: begin alu = 5'h05; return CatIZext; end
      6'h0F: begin alu = 5'h08; return CatIZext; end
      6'h23: begin alu = 5'h01; return CatLw; end
      6'h2B: begin alu = 5'h01; return CatSw; end
      default: return CatIll;
    endcase
    return CatIll;
  endfunction

  function automatic logic [31:0] rd_m(input logic [4:0] idx, input logic we,
                                      input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 5'd0) return 32'h0;
    if (we && wa == idx) return wd;
    return m_rf[idx];
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  task automatic cycle(input logic r, input logic v, input logic fl, input logic [31:0] inst,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    exp_t        e;
    cat_e        c;
    logic [4:0]  alu, rs, rt;
    logic [7:0]  pc;
    logic        frz_m, stall_m, has_imm, frz_issue;
    rs = inst[25:21]; rt = inst[20:16]; pc = 8'($urandom);
    rst = r; if_valid = v; flush = fl; if_inst = inst; if_pcadd = pc;
    wb_we = we; wb_addr = wa; wb_data = wd;
    while (ld_cyc.size() > 0 && cyc - ld_cyc[0] > int'(LOAD_LAT)) begin
      void'(ld_cyc.pop_front()); void'(ld_dst.pop_front());
    end
    frz_m   = (cyc <= frz_last);
    stall_m = 1'b0;
    foreach (ld_dst[i]) if (ld_dst[i] == int'(rs) || ld_dst[i] == int'(rt)) stall_m = 1'b1;
    stall_m = stall_m && v && !fl && !frz_m && !r;
    last_stall = stall_m;
    #1;
    check_eq("freeze", freeze, frz_m);
    if (freeze === 1'b1) frz_hi++;
    if (!r) begin
      check_eq("pc_write", pc_write, !stall_m);
      check_eq("ifid_write", ifid_write, !stall_m);
      if (pc_write === 1'b0) pcw_low++;
    end
    e = '0;
    c = classify(inst, alu);
    has_imm = c inside {CatCbr, CatISext, CatIZext, CatLw, CatSw, CatRShamt};
    if (!r && v && !fl && !frz_m && !stall_m) begin
      if (c == CatIll) e.ill = 1'b1;
      else if (c != CatNop) begin
        e.valid    = 1'b1;
        e.alu      = alu;
        e.regdst   = (inst[31:26] == 6'h00);
        e.regwrite = c inside {CatRAlu, CatRShamt, CatISext, CatIZext, CatLw};
        e.alusrc   = c inside {CatRShamt, CatISext, CatIZext, CatLw, CatSw};
        e.branch   = c inside {CatJr, CatJ, CatCbr};
        e.jump     = (c == CatJ);
        e.jr       = (c == CatJr);
        e.memtoreg = (c == CatLw);
        e.ld       = (c == CatLw);
        e.memwrite = (c == CatSw);
        e.pred     = (c == CatCbr) && BP_EN && inst[15];
        if (c inside {CatCbr, CatISext, CatLw, CatSw})
          e.imm = {{16{inst[15]}}, inst[15:0]};
        else if (has_imm) e.imm = {16'h0, inst[15:0]};
        e.rs = rs; e.rt = rt; e.rd = inst[15:11]; e.pcadd = pc;
        e.rs_data = rd_m(rs, we, wa, wd);
        e.rt_data = rd_m(rt, we, wa, wd);
      end
    end
    frz_issue = e.valid && (c == CatJ || c == CatJr ||
                            (c == CatCbr && !(BP_EN && !inst[15])));
    if (r) begin
      foreach (m_rf[i]) m_rf[i] = '0;
      ld_dst.delete(); ld_cyc.delete();
      frz_last = cyc;
    end else begin
      if (we && wa != 5'd0) m_rf[wa] = wd;
      if (e.valid && e.ld && rt != 5'd0) begin ld_dst.push_back(int'(rt)); ld_cyc.push_back(cyc); end
      if (fl) frz_last = cyc;
      else if (frz_issue) frz_last = cyc + int'(BR_SHADOW);
    end
    cyc++;
    @(posedge clk); #1;
    check_eq("ctrl", {ex_valid, ex_memtoreg, ex_memwrite, ex_branch, ex_alusrc, ex_regdst,
                      ex_regwrite, ex_jump, ex_jr, ex_ld, ex_pred_taken, ex_illegal, ex_alu_op},
             {e.valid, e.memtoreg, e.memwrite, e.branch, e.alusrc, e.regdst, e.regwrite,
              e.jump, e.jr, e.ld, e.pred, e.ill, e.alu});
    if (e.valid || r) begin
      check_eq("rs_data", ex_rs_data, e.rs_data);
      check_eq("rt_data", ex_rt_data, e.rt_data);
      check_eq("idx", {ex_rs, ex_rt, ex_rd}, {e.rs, e.rt, e.rd});
      check_eq("pcadd", ex_pcadd, e.pcadd);
      if (has_imm || r) check_eq("imm", ex_imm, e.imm);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] im;
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7)); sh = 5'($urandom_range(0, 3));
    im = 16'($urandom);
    case ($urandom_range(0, 23))
      0: return enc_r(6'h20, rs, rt, rd, 5'd0);
      1: return enc_r(6'h23, rs, rt, rd, 5'd0);
      2: return enc_r(6'h24, rs, rt, rd, 5'd0);
      3: return enc_r(6'h27, rs, rt, rd, 5'd0);
      4: return enc_r(6'h00, rs, rt, rd, sh);
      5: return enc_r(6'h02, rs, rt, rd, sh);
      6: return enc_r(6'h04, rs, rt, rd, 5'd0);
      7: return enc_r(6'h06, rs, rt, rd, 5'd0);
      8: return enc_r(6'h08, rs, 5'd0, 5'd0, 5'd0);
      9: return enc_i(6'h01, rs, 5'($urandom_range(0, 2)), im);
      10: return {6'h02, 26'($urandom)};
      11: return enc_i(6'h04, rs, rt, im);
      12: return enc_i(6'h05, rs, rt, im);
      13: return enc_i(6'h07, rs, 5'd0, im);
      14: return enc_i(6'h08, rs, rt, im);
      15: return enc_i(6'h0C, rs, rt, im);
      16: return enc_i(6'h0D, rs, rt, im);
      17: return enc_i(6'h0E, rs, rt, im);
      18: return enc_i(6'h0F, 5'd0, rt, im);
      19, 20: return enc_i(6'h23, rs, rt, im);
      21: return enc_i(6'h2B, rs, rt, im);
      22: return enc_r(6'h3F, rs, rt, rd, 5'd0);
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] cur;

  initial begin
    rst = 1'b1; if_valid = 1'b0; flush = 1'b0; if_inst = '0; if_pcadd = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    @(negedge clk);
    cycle(1, 0, 0, 32'h0, 0, 5'd0, 32'h0);
    // add r3,r1,r2 with preloaded operands
    cycle(0, 0, 0, 32'h0, 1, 5'd1, 32'd5);
    cycle(0, 0, 0, 32'h0, 1, 5'd2, 32'd7);
    cycle(0, 1, 0, enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0), 0, 5'd0, 32'h0);
    check_eq("add_alu", ex_alu_op, 5'h01);
    check_eq("add_rs", ex_rs_data, 32'd5);
    check_eq("add_rt", ex_rt_data, 32'd7);
    check_eq("add_regdst_valid", {ex_regdst, ex_valid}, 2'b11);
    // load-use with consumer immediately behind, then with r0 as destination
    pcw_low = 0;
    cycle(0, 1, 0, enc_i(6'h23, 5'd1, 5'd4, 16'h0), 0, 5'd0, 32'h0);
    repeat (3) cycle(0, 1, 0, enc_r(6'h20, 5'd4, 5'd4, 5'd5, 5'd0), 0, 5'd0, 32'h0);
    check_eq("lu_stall_cycles", pcw_low, 2);
    check_eq("lu_add_issued", ex_valid, 1'b1);
    pcw_low = 0;
    cycle(0, 1, 0, enc_i(6'h23, 5'd1, 5'd0, 16'h0), 0, 5'd0, 32'h0);
    cycle(0, 1, 0, enc_r(6'h20, 5'd0, 5'd0, 5'd5, 5'd0), 0, 5'd0, 32'h0);
    check_eq("lu_r0_no_stall", pcw_low, 0);
    // backward beq is predicted taken and freezes; forward one does not
    frz_hi = 0;
    cycle(0, 1, 0, enc_i(6'h04, 5'd1, 5'd2, 16'hFFFC), 0, 5'd0, 32'h0);
    check_eq("beq_pred", ex_pred_taken, 1'b1);
    check_eq("beq_imm", ex_imm, 32'hFFFF_FFFC);
    repeat (3) cycle(0, 1, 0, 32'h0, 0, 5'd0, 32'h0);
    check_eq("beq_freeze_cycles", frz_hi, 2);
    frz_hi = 0;
    cycle(0, 1, 0, enc_i(6'h04, 5'd1, 5'd2, 16'h0004), 0, 5'd0, 32'h0);
    check_eq("fwd_pred", ex_pred_taken, 1'b0);
    repeat (2) cycle(0, 1, 0, 32'h0, 0, 5'd0, 32'h0);
    check_eq("fwd_no_freeze", frz_hi, 0);
    // jump followed by flush in the first shadow cycle
    frz_hi = 0;
    cycle(0, 1, 0, {6'h02, 26'h12345}, 0, 5'd0, 32'h0);
    cycle(0, 1, 1, enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0), 0, 5'd0, 32'h0);
    check_eq("flush_bubble", ex_valid, 1'b0);
    cycle(0, 1, 0, enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0), 0, 5'd0, 32'h0);
    check_eq("flush_freeze_cycles", frz_hi, 1);
    // write-through and r0
    cycle(0, 1, 0, enc_r(6'h25, 5'd9, 5'd0, 5'd2, 5'd0), 1, 5'd9, 32'hDEAD_BEEF);
    check_eq("wt_rs", ex_rs_data, 32'hDEAD_BEEF);
    cycle(0, 0, 0, 32'h0, 1, 5'd0, 32'h1234_5678);
    cycle(0, 1, 0, enc_r(6'h25, 5'd0, 5'd0, 5'd2, 5'd0), 0, 5'd0, 32'h0);
    check_eq("r0_zero", ex_rs_data, 32'h0);
    // illegal opcode, then reset during a load stall
    cycle(0, 1, 0, 32'hFC00_0000, 0, 5'd0, 32'h0);
    check_eq("ill", {ex_illegal, ex_valid, ex_regwrite}, 3'b100);
    cycle(0, 1, 0, enc_i(6'h23, 5'd1, 5'd4, 16'h0), 0, 5'd0, 32'h0);
    cycle(0, 1, 0, enc_r(6'h20, 5'd4, 5'd4, 5'd5, 5'd0), 0, 5'd0, 32'h0);
    cycle(1, 1, 0, enc_r(6'h20, 5'd4, 5'd4, 5'd5, 5'd0), 0, 5'd0, 32'h0);
    check_eq("rst_valid", ex_valid, 1'b0);
    cycle(0, 1, 0, enc_r(6'h20, 5'd4, 5'd4, 5'd5, 5'd0), 0, 5'd0, 32'h0);
    check_eq("post_rst_issue", ex_valid, 1'b1);
    // random traffic; IF/ID holds its instruction while stalled
    cur = rand_inst();
    for (int n = 0; n < 3000; n++) begin
      if (!last_stall) cur = rand_inst();
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 11) == 0), cur, 1'($urandom), 5'($urandom_range(0, 7)),
            $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
